// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from a first-word-fall-through TX FIFO and
// serialises them LSB-first with start bit, optional parity and 1 or 2 stop bits.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       tx_empty,
  input  logic [7:0] uart_data,
  output logic       uart_read,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LOAD = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] baud_cnt, cnt_nxt;
  logic [2:0]    bit_idx, idx_nxt;
  logic          stop_idx, stop_nxt;
  logic [7:0]    shift_reg, shift_nxt;
  logic          txd_reg, txd_nxt;
  logic          bit_end, last_stop, frame_end, pop, parity_bit;

  assign bit_end    = (baud_cnt == '0);
  assign last_stop  = (STOP_BITS == 1) || stop_idx;
  assign frame_end  = (state == STOP) && bit_end && last_stop;
  // Gated by rst_n so the FIFO is never popped while the engine is held in reset.
  assign pop        = rst_n && tx_en && !tx_empty && ((state == IDLE) || frame_end);
  assign parity_bit = (PARITY_ODD != 0) ? ~^shift_reg : ^shift_reg;

  assign uart_read = pop;
  assign uart_txd  = txd_reg;
  assign tx_busy   = (state != IDLE);
  assign tx_done   = frame_end;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = baud_cnt - CW'(1);
    idx_nxt   = bit_idx;
    stop_nxt  = stop_idx;
    shift_nxt = shift_reg;
    case (state)
      IDLE: begin
        cnt_nxt = baud_cnt;
        if (pop) begin
          state_nxt = START;
          cnt_nxt   = BAUD_LOAD;
          shift_nxt = uart_data;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          cnt_nxt   = BAUD_LOAD;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = BAUD_LOAD;
          if (bit_idx == 3'd7) begin
            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            idx_nxt   = '0;
            stop_nxt  = 1'b0;
          end else begin
            idx_nxt = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          cnt_nxt   = BAUD_LOAD;
          stop_nxt  = 1'b0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!last_stop) begin
            stop_nxt = 1'b1;
            cnt_nxt  = BAUD_LOAD;
          end else if (pop) begin
            state_nxt = START;
            cnt_nxt   = BAUD_LOAD;
            shift_nxt = uart_data;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The line level is decided from the next state so the pin is a clean register output.
  always_comb begin
    txd_nxt = 1'b1;
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[idx_nxt];
      PARITY:  txd_nxt = parity_bit;
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= cnt_nxt;
      bit_idx   <= idx_nxt;
      stop_idx  <= stop_nxt;
      shift_reg <= shift_nxt;
      txd_reg   <= txd_nxt;
    end
  end

endmodule
